// File: rtl/assert_pkg.sv
// Shared constants and types for the assertion reporter.
package assert_pkg;

    localparam logic [7:0] FRAME_HDR = 8'hA5;
    localparam int         FRAME_LEN = 6;

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    typedef logic [31:0] stamp_t;

endpackage

// File: rtl/assert_lsb_pick.sv
// Lowest-set-bit encoder: returns the smallest index with mask[i]=1.
module assert_lsb_pick #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] mask,
    output logic [7:0]       idx,
    output logic             found
);

    // Scan high to low so the last hit (lowest index) wins.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (mask[i]) begin
                idx   = 8'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/assert_reporter.sv
// Assertion reporter: sticky failure status, saturating count, first-fail
// timestamps and a 6-byte report frame per newly failing checker.
//
// state | meaning
// IDLE  | waiting for a pending checker; picks lowest index into shadow regs
// SEND  | presenting frame byte byte_idx on the valid/ready byte stream
module assert_reporter
    import assert_pkg::*;
#(
    parameter int NUM_CHK = 8,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               clear,
    input  logic [NUM_CHK-1:0] chk_in,
    output logic [7:0]         tx_data,
    output logic               tx_valid,
    input  logic               tx_ready,
    output logic               fail_any,
    output logic [NUM_CHK-1:0] fail_mask,
    output logic [CNT_W-1:0]   fail_count
);

    // Sum is wide enough for the counter plus a full popcount of up to 255 lines.
    localparam int SUM_W = ((CNT_W > 9) ? CNT_W : 9) + 1;

    function automatic logic [8:0] popcount(input logic [NUM_CHK-1:0] v);
        logic [8:0] n;
        n = '0;
        for (int i = 0; i < NUM_CHK; i++) n = n + 9'(v[i]);
        return n;
    endfunction

    function automatic logic [7:0] frame_byte(input logic [2:0] sel,
                                              input logic [7:0] idx,
                                              input stamp_t     st);
        case (sel)
            3'd0:    return FRAME_HDR;
            3'd1:    return idx;
            3'd2:    return st[31:24];
            3'd3:    return st[23:16];
            3'd4:    return st[15:8];
            3'd5:    return st[7:0];
            default: return 8'h00;
        endcase
    endfunction

    stamp_t             cyc_cnt;
    stamp_t             stamp [NUM_CHK];
    logic [NUM_CHK-1:0] pending;
    logic [NUM_CHK-1:0] fails;
    logic [NUM_CHK-1:0] newly;
    logic [NUM_CHK-1:0] take_mask;
    logic [SUM_W-1:0]   sum;
    logic [7:0]         pick_idx;
    logic               pick_found;
    logic               take;
    stamp_t             pick_stamp;

    state_t             state;
    logic [2:0]         byte_idx;
    logic [7:0]         shadow_idx;
    stamp_t             shadow_stamp;

    assert_lsb_pick #(.WIDTH(NUM_CHK)) u_pick (
        .mask  (pending),
        .idx   (pick_idx),
        .found (pick_found)
    );

    // Failures seen this edge, the subset that is new, and the saturating sum.
    always_comb begin
        fails     = (enable && !clear) ? ~chk_in : '0;
        newly     = fails & ~fail_mask;
        sum       = SUM_W'(fail_count) + SUM_W'(popcount(fails));
        take      = (state == IDLE) && !clear && pick_found;
        take_mask = take ? (NUM_CHK'(1) << pick_idx) : '0;
    end

    // Stamp lookup for the checker the FSM is about to frame.
    always_comb begin
        pick_stamp = '0;
        for (int i = 0; i < NUM_CHK; i++) begin
            if (pick_idx == 8'(i)) pick_stamp = stamp[i];
        end
    end

    assign fail_any = |fail_mask;

    // Cycle counter, sticky mask, saturating count and pending frames.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_cnt    <= '0;
            fail_mask  <= '0;
            fail_count <= '0;
            pending    <= '0;
        end else if (clear) begin
            cyc_cnt    <= '0;
            fail_mask  <= '0;
            fail_count <= '0;
            pending    <= '0;
        end else begin
            if (enable) cyc_cnt <= cyc_cnt + 32'd1;
            fail_mask <= fail_mask | fails;
            if (sum[SUM_W-1:CNT_W] != '0) fail_count <= '1;
            else                           fail_count <= sum[CNT_W-1:0];
            pending <= (pending & ~take_mask) | newly;
        end
    end

    // First-failure timestamps use the counter value before this edge's increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CHK; i++) stamp[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_CHK; i++) begin
                if (clear)         stamp[i] <= '0;
                else if (newly[i]) stamp[i] <= cyc_cnt;
            end
        end
    end

    // Frame sequencer; a frame in SEND finishes from shadow regs even across clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            byte_idx     <= '0;
            shadow_idx   <= '0;
            shadow_stamp <= '0;
            tx_valid     <= 1'b0;
            tx_data      <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (take) begin
                        shadow_idx   <= pick_idx;
                        shadow_stamp <= pick_stamp;
                        byte_idx     <= '0;
                        tx_valid     <= 1'b1;
                        tx_data      <= FRAME_HDR;
                        state        <= SEND;
                    end
                end
                SEND: begin
                    if (tx_ready) begin
                        if (byte_idx == 3'(FRAME_LEN - 1)) begin
                            tx_valid <= 1'b0;
                            state    <= IDLE;
                        end else begin
                            byte_idx <= byte_idx + 3'd1;
                            tx_data  <= frame_byte(byte_idx + 3'd1, shadow_idx, shadow_stamp);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_assert_reporter.sv
// Directed bench for assert_reporter: default instance plus a CNT_W=4 instance
// sharing the same stimulus for the saturation case.
module tb_assert_reporter;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        clear;
    logic [7:0]  chk_in;
    logic        tx_ready;

    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        fail_any;
    logic [7:0]  fail_mask;
    logic [15:0] fail_count;

    logic [7:0]  s_tx_data;
    logic        s_tx_valid;
    logic        s_fail_any;
    logic [7:0]  s_fail_mask;
    logic [3:0]  s_fail_count;

    int passed = 0;
    int total  = 0;
    int nfail  = 0;
    logic [7:0] fr [6];

    always #5 clk = ~clk;

    assert_reporter #(.NUM_CHK(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .enable(enable), .clear(clear), .chk_in(chk_in),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .fail_any(fail_any), .fail_mask(fail_mask), .fail_count(fail_count)
    );

    assert_reporter #(.NUM_CHK(8), .CNT_W(4)) dut_s (
        .clk(clk), .rst(rst), .enable(enable), .clear(clear), .chk_in(chk_in),
        .tx_data(s_tx_data), .tx_valid(s_tx_valid), .tx_ready(tx_ready),
        .fail_any(s_fail_any), .fail_mask(s_fail_mask), .fail_count(s_fail_count)
    );

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Collects one frame into fr[]; bp toggles tx_ready 0,0,1; clr_at pulses
    // clear on the cycle byte clr_at is being accepted.
    task automatic get_frame(input bit bp, input int clr_at);
        int n = 0;
        int guard = 0;
        int ph = 0;
        bit holding = 1'b0;
        logic [7:0] held = 8'h00;
        while (n < 6 && guard < 200) begin
            tx_ready = bp ? (ph == 2) : 1'b1;
            ph = (ph == 2) ? 0 : ph + 1;
            clear = (n == clr_at);
            if (tx_valid) begin
                if (holding) chk("bp_stable", {24'h0, tx_data}, {24'h0, held});
                if (tx_ready) begin
                    fr[n] = tx_data;
                    n++;
                    holding = 1'b0;
                end else begin
                    held = tx_data;
                    holding = 1'b1;
                end
            end
            step();
            guard++;
        end
        clear = 1'b0;
        tx_ready = 1'b1;
        chk("frame_complete", n, 6);
    endtask

    task automatic chk_frame(input string tag, input logic [7:0] idx, input logic [31:0] st);
        chk({tag, "_b0"}, {24'h0, fr[0]}, 32'hA5);
        chk({tag, "_b1"}, {24'h0, fr[1]}, {24'h0, idx});
        chk({tag, "_b2"}, {24'h0, fr[2]}, {24'h0, st[31:24]});
        chk({tag, "_b3"}, {24'h0, fr[3]}, {24'h0, st[23:16]});
        chk({tag, "_b4"}, {24'h0, fr[4]}, {24'h0, st[15:8]});
        chk({tag, "_b5"}, {24'h0, fr[5]}, {24'h0, st[7:0]});
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    initial begin
        int seen;
        rst = 1'b1; enable = 1'b0; clear = 1'b0; chk_in = 8'hFF; tx_ready = 1'b1;
        step(3);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_fail_any", fail_any, 0);
        chk("rst_fail_mask", fail_mask, 0);
        chk("rst_fail_count", fail_count, 0);

        // Single failure at cyc_cnt=10.
        rst = 1'b0; enable = 1'b1;
        step(10);
        chk_in = 8'hFB;
        step();
        chk_in = 8'hFF;
        chk("single_mask", fail_mask, 32'h04);
        chk("single_count", fail_count, 1);
        chk("single_any", fail_any, 1);
        chk("single_not_yet_valid", tx_valid, 0);
        step();
        chk("single_valid_rise", tx_valid, 1);
        get_frame(1'b0, -1);
        chk_frame("single", 8'h02, 32'd10);

        // Simultaneous failures of checkers 4 and 7 at cyc_cnt=3.
        do_clear();
        chk("clr1_mask", fail_mask, 0);
        chk("clr1_count", fail_count, 0);
        step(3);
        chk_in = 8'h6F;
        step();
        chk_in = 8'hFF;
        chk("simul_count", fail_count, 2);
        chk("simul_mask", fail_mask, 32'h90);
        step();
        get_frame(1'b0, -1);
        chk_frame("simul_a", 8'h04, 32'd3);
        chk("simul_idle_gap", tx_valid, 0);
        step();
        chk("simul_second_valid", tx_valid, 1);
        get_frame(1'b0, -1);
        chk_frame("simul_b", 8'h07, 32'd3);

        // Repeat failures of checker 0 for 20 cycles; saturation on CNT_W=4.
        do_clear();
        chk_in = 8'hFE;
        step(2);
        get_frame(1'b0, -1);
        chk_frame("repeat", 8'h00, 32'd0);
        step(12);
        chk_in = 8'hFF;
        chk("sat_count_w4", s_fail_count, 15);
        chk("sat_mask_w4", s_fail_mask, 32'h01);
        chk("repeat_count_w16", fail_count, 20);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (tx_valid) seen++;
            step();
        end
        chk("repeat_single_frame", seen, 0);

        // Backpressure on a frame for checker 1 stamped at 5.
        do_clear();
        step(5);
        chk_in = 8'hFD;
        step();
        chk_in = 8'hFF;
        step();
        get_frame(1'b1, -1);
        chk_frame("bp", 8'h01, 32'd5);

        // Clear while byte 2 is on the bus; the frame still completes.
        do_clear();
        step(2);
        chk_in = 8'hF7;
        step();
        chk_in = 8'hFF;
        step();
        get_frame(1'b0, 2);
        chk_frame("clrmid", 8'h03, 32'd2);
        chk("clrmid_mask", fail_mask, 0);
        chk("clrmid_count", fail_count, 0);
        chk("clrmid_idle", tx_valid, 0);
        chk_in = 8'hF7;
        step();
        chk_in = 8'hFF;
        chk("clrmid_remask", fail_mask, 32'h08);
        step();
        get_frame(1'b0, -1);
        chk_frame("clrmid_again", 8'h03, 32'd3);

        // Asynchronous reset while byte 3 is on the bus.
        do_clear();
        step();
        chk_in = 8'hFB;
        step();
        chk_in = 8'hFF;
        step();
        chk("arst_frame_start", tx_valid, 1);
        step(3);
        chk("arst_pre_valid", tx_valid, 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid_drop", tx_valid, 0);
        chk("arst_data", tx_data, 0);
        chk("arst_mask", fail_mask, 0);
        chk("arst_count", fail_count, 0);
        chk("arst_any", fail_any, 0);
        #1 rst = 1'b0;
        step();
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (tx_valid) seen++;
            step();
        end
        chk("arst_no_resume", seen, 0);
        chk("arst_post_mask", fail_mask, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/assert_reporter.md
# assert_reporter

Synthesizable consumer for per-cycle assertion signals on the FPGA. Samples up to NUM_CHK pass/fail checker lines every clock, keeps sticky failure status and a saturating failure count, and timestamps the first failure of each checker. Emits one 6-byte report frame per newly failing checker over a valid/ready byte stream, intended to feed the UART transmitter, so assertion hits surface on hardware without simulator `$display`.

## Interface
- NUM_CHK, 8: number of checker inputs (1..255)
- CNT_W, 16: width of the failure counter
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- enable  in  1  sampling and cycle counting enabled
- clear  in  1  synchronous clear of status, count, pending and timestamps
- chk_in  in  NUM_CHK  checker lines; 1 = pass, 0 = fail
- tx_data  out  8  report byte
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  sink accepts byte
- fail_any  out  1  sticky OR of fail_mask
- fail_mask  out  NUM_CHK  sticky per-checker failure flags
- fail_count  out  CNT_W  total failed checker-cycles, saturating

## Operation
- cyc_cnt: 32-bit, reset 0, +1 on every edge with enable=1, wraps at 2^32-1 → 0.
- Sampling, at an edge with enable=1 and clear=0: fails = ~chk_in.
  - fail_mask |= fails.
  - fail_count += popcount(fails), saturating at all-ones.
  - For each bit newly set in fail_mask: stamp[i] <= cyc_cnt pre-increment value, and pending[i] <= 1.
  - Bits already set in fail_mask: count only. No new stamp, no new frame.
- With enable=0: no sampling, no counting, cyc_cnt frozen. The FSM keeps draining.
- Frame format, bytes 0..5: 0xA5, checker index, stamp[31:24], [23:16], [15:8], [7:0].
- FSM states:
  - IDLE: if pending≠0, pick the lowest set index, copy index and stamp into shadow registers, clear that pending bit, go to SEND with byte_idx=0.
  - SEND: tx_valid=1 and tx_data = byte[byte_idx] from the shadow registers. On tx_valid&tx_ready: if byte_idx=5, go to IDLE; else byte_idx+1.
- Handshake: once tx_valid is raised, it stays high and tx_data stays stable until accepted. One byte per accepted cycle. tx_ready may be held high permanently.
- clear=1:
  - Zeroes fail_mask, fail_count, pending, stamps and cyc_cnt. Failures on that edge are dropped.
  - A frame already in SEND completes from its shadow registers.
- Each checker is reported at most once between clears.
- Simultaneous new failures share one timestamp and are framed in ascending index order.

## Timing
- Reset values:
  - tx_valid=0, tx_data=0x00.
  - fail_any=0, fail_mask=0, fail_count=0.
  - cyc_cnt=0, pending=0, FSM=IDLE.
- Status latency: chk_in[i]=0 sampled at edge N → fail_mask[i], fail_any and fail_count updated after edge N.
- Report latency: for that failure, with the FSM in IDLE, tx_valid rises after edge N+1 with byte 0xA5.
- Frame length: 6 accepted bytes. Minimum 7 cycles from IDLE to the next IDLE→SEND decision with tx_ready=1.
- Back-to-back frames: one IDLE cycle between frames.
- Asynchronous reset mid-frame: the frame is abandoned immediately and tx_valid drops without waiting for a handshake.

## Structure
- Package assert_pkg holds:
  - the FRAME_HDR=8'hA5 and FRAME_LEN=6 constants;
  - the FSM state enum (IDLE, SEND);
  - a 32-bit stamp typedef.
- Sub-module assert_lsb_pick: combinational lowest-set-bit encoder, NUM_CHK-wide mask → index plus found flag. Used by the IDLE state.
- The popcount stays an inline function.

## Test plan
- Single failure: reset, enable=1, tx_ready=1, chk_in=8'hFF; drive chk_in=8'hFB for one cycle at cyc_cnt=10.
  - Expect fail_mask=0x04 and fail_count=1.
  - Expect frame A5 02 00 00 00 0A.
- Simultaneous failures: chk_in=8'h6F for one cycle at cyc_cnt=3.
  - Expect fail_count=2.
  - Expect two frames: A5 04 00 00 00 03, then A5 07 00 00 00 03.
- Repeat and saturation: CNT_W=4, hold chk_in[0]=0 for 20 cycles.
  - Expect fail_count stuck at 15.
  - Expect exactly one frame, for index 00.
- Backpressure: tx_ready toggles 0,0,1 repeatedly during a frame.
  - Expect tx_data stable while tx_valid&!tx_ready.
  - Expect all 6 bytes delivered in order with no duplicates.
- Clear mid-frame: assert clear during byte 2 of a frame.
  - Expect the frame to complete intact.
  - Expect fail_mask=0 and fail_count=0 afterwards.
  - A new failure of the same checker is reported again, with stamp counted from 0.
- Async reset mid-frame: pulse rst between clock edges during byte 3.
  - Expect tx_valid=0 immediately.
  - Expect all status at 0 and no frame resumed after release.
